muldiv_unit: RTL and testbench

- Multi-cycle MIPS multiply/divide engine for MULT, MULTU, DIV and DIVU.
- Produces the hi_req/lo_req write requests consumed by the HI/LO register block, so it is the writer side of the hilo write-request interface.
- Sits in the execute stage. The pipeline stalls while the unit is busy.
- Radix-2 iterative divider; fixed-latency multiplier.

---
 rtl/muldiv_unit.sv | 162 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 155 +++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Multi-cycle MIPS MULT/MULTU/DIV/DIVU engine. Writes the HI/LO registers through
// {valid, data} requests that are valid only during the single DONE cycle.
module muldiv_unit #(
  parameter int MUL_LATENCY = 3,
  parameter int DIV_ITERS   = 32
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        flush,
  output logic        ready,
  output logic        busy,
  output logic        done,
  output logic [32:0] hi_req,
  output logic [32:0] lo_req
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_DIV, S_FIX, S_DONE} state_e;
  localparam int CW = 6;

  state_e      state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]  op_q, op_d;
  logic [31:0] a_q, a_d, b_q, b_d;
  logic [31:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [31:0] hi_q, hi_d, lo_q, lo_d;
  logic        qneg_q, qneg_d, rneg_q, rneg_d;

  logic        accept, signed_op, sa, sb, vld;
  logic [63:0] ma, mb, prod;
  logic [32:0] rem_sh, trial;

  assign accept    = (state_q == S_IDLE) && start && !flush;
  assign signed_op = ~op_q[0];
  assign sa        = signed_op & a_q[31];
  assign sb        = signed_op & b_q[31];

  // Sign-extending to 64 bits lets one unsigned multiplier serve both MULT and MULTU.
  assign ma   = {{32{sa}}, a_q};
  assign mb   = {{32{sb}}, b_q};
  assign prod = ma * mb;

  assign rem_sh = {rem_q, quo_q[31]};
  assign trial  = rem_sh - {1'b0, dvs_q};

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (start) state_d = op[1] ? S_DIV : S_MUL;
        S_MUL:  if (cnt_q == CW'(MUL_LATENCY - 1)) state_d = S_DONE;
        S_DIV:  if (cnt_q == CW'(DIV_ITERS)) state_d = S_FIX;
        S_FIX:  state_d = S_DONE;
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_d  = cnt_q;
    op_d   = op_q;
    a_d    = a_q;
    b_d    = b_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    hi_d   = hi_q;
    lo_d   = lo_q;
    qneg_d = qneg_q;
    rneg_d = rneg_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          op_d  = op;
          a_d   = a;
          b_d   = b;
          cnt_d = '0;
        end
      end
      S_MUL: begin
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == CW'(MUL_LATENCY - 1)) begin
          hi_d = prod[63:32];
          lo_d = prod[31:0];
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + CW'(1);
        // Count 0 is the magnitude setup; counts 1..DIV_ITERS are restoring steps.
        if (cnt_q == '0) begin
          rem_d  = '0;
          quo_d  = sa ? (~a_q + 32'd1) : a_q;
          dvs_d  = sb ? (~b_q + 32'd1) : b_q;
          qneg_d = sa ^ sb;
          rneg_d = sa;
        end else if (!trial[32]) begin
          rem_d = trial[31:0];
          quo_d = {quo_q[30:0], 1'b1};
        end else begin
          rem_d = rem_sh[31:0];
          quo_d = {quo_q[30:0], 1'b0};
        end
      end
      S_FIX: begin
        if (b_q == '0) begin
          hi_d = a_q;
          lo_d = 32'hFFFF_FFFF;
        end else begin
          hi_d = rneg_q ? (~rem_q + 32'd1) : rem_q;
          lo_d = qneg_q ? (~quo_q + 32'd1) : quo_q;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    ready  = (state_q == S_IDLE);
    busy   = (state_q != S_IDLE);
    done   = (state_q == S_DONE);
    vld    = done && !flush;
    hi_req = {vld, hi_q};
    lo_req = {vld, lo_q};
  end

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: latency, results, flush, reset and busy behaviour.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        resetn = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic [1:0]  op = 2'd0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        ready, busy, done;
  logic [32:0] hi_req, lo_req;
  int          n_err = 0;
  int          n_chk = 0;
  int          seen;

  always #5 clk = ~clk;

  muldiv_unit #(.MUL_LATENCY(3), .DIV_ITERS(32)) dut (
    .clk(clk), .resetn(resetn), .start(start), .op(op), .a(a), .b(b), .flush(flush),
    .ready(ready), .busy(busy), .done(done), .hi_req(hi_req), .lo_req(lo_req)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x,
                       input logic [31:0] y, input logic [31:0] ehi, input logic [31:0] elo,
                       input int elat, input bit poke);
    int k;
    int extra;
    bit bad;
    chk({tag, " ready_before"}, 64'(ready), 64'd1);
    start = 1'b1; op = o; a = x; b = y;
    tick;
    start = 1'b0; a = $urandom; b = $urandom; op = 2'($urandom);
    k = 0; bad = 1'b0;
    while (!done && k < 100) begin
      if (busy !== 1'b1 || ready !== 1'b0 || hi_req[32] || lo_req[32]) bad = 1'b1;
      if (poke && k == 5) start = 1'b1;
      tick;
      if (poke && k == 5) start = 1'b0;
      k++;
    end
    chk({tag, " latency"}, 64'(k), 64'(elat));
    chk({tag, " busy_ready_bad"}, {61'd0, busy, ready, bad}, 64'b100);
    chk({tag, " hi_req"}, 64'(hi_req), {31'd0, 1'b1, ehi});
    chk({tag, " lo_req"}, 64'(lo_req), {31'd0, 1'b1, elo});
    tick;
    chk({tag, " after_done"}, {59'd0, done, hi_req[32], lo_req[32], ready, busy}, 64'b00010);
    extra = 0;
    repeat (8) begin
      tick;
      if (done || hi_req[32] || lo_req[32]) extra++;
    end
    chk({tag, " no_extra_done"}, 64'(extra), 64'd0);
  endtask

  initial begin
    tick;
    tick;
    chk("reset ctrl", {61'd0, ready, busy, done}, 64'b100);
    chk("reset hi_req", 64'(hi_req), 64'd0);
    chk("reset lo_req", 64'(lo_req), 64'd0);
    resetn = 1'b1;
    tick;

    do_op("MULT -2*3",      2'd0, 32'hFFFF_FFFE, 32'd3,         32'hFFFF_FFFF, 32'hFFFF_FFFA, 3, 1'b0);
    do_op("MULTU max*max",  2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 3, 1'b0);
    do_op("MULT 7*-3",      2'd0, 32'd7,         32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 3, 1'b0);
    do_op("MULTU 2^16*2^16",2'd1, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 3, 1'b0);
    do_op("DIV -7/2",       2'd2, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 1'b0);
    do_op("DIV 7/-2",       2'd2, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD, 34, 1'b0);
    do_op("DIVU 100/7 poke",2'd3, 32'd100,       32'd7,         32'd2,         32'd14,        34, 1'b1);
    do_op("DIVU 5/0",       2'd3, 32'd5,         32'd0,         32'd5,         32'hFFFF_FFFF, 34, 1'b0);
    do_op("DIV -5/0",       2'd2, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFB, 32'hFFFF_FFFF, 34, 1'b0);
    do_op("DIV ovf",        2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, 34, 1'b0);

    // Flush in the middle of a divide.
    seen = 0;
    start = 1'b1; op = 2'd2; a = 32'd1000; b = 32'd3;
    tick;
    start = 1'b0;
    for (int i = 0; i < 9; i++) begin
      tick;
      if (hi_req[32] || lo_req[32] || done) seen++;
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    chk("flush_div ready_busy", {62'd0, ready, busy}, 64'b10);
    for (int i = 0; i < 40; i++) begin
      tick;
      if (hi_req[32] || lo_req[32] || done) seen++;
    end
    chk("flush_div no_write", 64'(seen), 64'd0);

    // Flush coinciding with the DONE cycle.
    start = 1'b1; op = 2'd0; a = 32'd2; b = 32'd3;
    tick;
    start = 1'b0;
    tick;
    tick;
    tick;
    chk("flush_done done", 64'(done), 64'd1);
    flush = 1'b1;
    #1;
    chk("flush_done valids", {62'd0, hi_req[32], lo_req[32]}, 64'd0);
    tick;
    flush = 1'b0;
    chk("flush_done idle", {62'd0, ready, done}, 64'b10);

    // start and flush together.
    seen = 0;
    start = 1'b1; flush = 1'b1; op = 2'd0; a = 32'd5; b = 32'd5;
    tick;
    start = 1'b0; flush = 1'b0;
    chk("start_flush not_accepted", {62'd0, ready, busy}, 64'b10);
    repeat (6) begin
      tick;
      if (done || busy) seen++;
    end
    chk("start_flush quiet", 64'(seen), 64'd0);

    // Reset in the middle of a divide.
    seen = 0;
    start = 1'b1; op = 2'd3; a = 32'd77; b = 32'd5;
    tick;
    start = 1'b0;
    repeat (14) tick;
    resetn = 1'b0;
    tick;
    chk("mid_reset ctrl", {61'd0, ready, busy, done}, 64'b100);
    chk("mid_reset hi_req", 64'(hi_req), 64'd0);
    chk("mid_reset lo_req", 64'(lo_req), 64'd0);
    resetn = 1'b1;
    repeat (40) begin
      tick;
      if (done || hi_req[32] || lo_req[32]) seen++;
    end
    chk("mid_reset no_write", 64'(seen), 64'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
